// File: rtl/rect_fall_ctl_pkg.sv
// Constants and helpers for the rectangle fall/bounce sequencer.
package rect_fall_ctl_pkg;

   localparam int POS_W = 12;         // pixel coordinate width

   // Motion defaults; velocities are in 1/16 px per frame.
   localparam int DEF_GRAVITY    = 4;
   localparam int DEF_VMAX       = 512;
   localparam int DEF_DAMP_SHIFT = 2;
   localparam int DEF_STOP_VEL   = 16;

   // Saturate a pixel coordinate at an upper limit.
   function automatic logic [POS_W-1:0] clamp_px(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/vga_pkg.sv
// Screen geometry shared by the VGA timing chain and the overlay draw stages.
package vga_pkg;

   localparam int HOR_PIXELS = 800;   // visible pixels per line
   localparam int VER_PIXELS = 600;   // visible lines per frame
   localparam int RECT_W     = 48;    // overlay rectangle width, px
   localparam int RECT_H     = 64;    // overlay rectangle height, px

endpackage

// File: rtl/rect_fall_ctl_if.sv
// Mouse-in / rectangle-position-out bundle for the rectangle sequencer.
interface rect_fall_ctl_if;
   import rect_fall_ctl_pkg::*;

   logic             vblnk;
   logic [POS_W-1:0] mouse_xpos;
   logic [POS_W-1:0] mouse_ypos;
   logic             mouse_left;
   logic [POS_W-1:0] rect_x_position;
   logic [POS_W-1:0] rect_y_position;
   logic             falling;

   // Timing chain / mouse side drives the inputs and reads the position.
   modport master (
      output vblnk, mouse_xpos, mouse_ypos, mouse_left,
      input  rect_x_position, rect_y_position, falling
   );

   // The sequencer itself.
   modport slave (
      input  vblnk, mouse_xpos, mouse_ypos, mouse_left,
      output rect_x_position, rect_y_position, falling
   );

endinterface

// File: rtl/rect_fall_ctl_edge_rise.sv
// Registered rising-edge detector: one-cycle pulse in the cycle the input goes high.
module edge_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic din_q;

   // Remember the input level from the previous cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) din_q <= 1'b0;
      else        din_q <= din;
   end

   assign pulse = din & ~din_q;

endmodule

// File: rtl/rect_fall_ctl.sv
// Rectangle overlay sequencer: tracks the mouse, drops with gravity on click,
// bounces on the floor with damping and rests until the next click.
// All position updates happen once per frame, at the vblank rising edge.
module rect_fall_ctl
   import vga_pkg::*;
   import rect_fall_ctl_pkg::*;
#(
   parameter int SCREEN_W   = HOR_PIXELS,
   parameter int SCREEN_H   = VER_PIXELS,
   parameter int GRAVITY    = DEF_GRAVITY,
   parameter int VMAX       = DEF_VMAX,
   parameter int DAMP_SHIFT = DEF_DAMP_SHIFT,
   parameter int STOP_VEL   = DEF_STOP_VEL
) (
   input  logic           clk,
   input  logic           rst_n,
   rect_fall_ctl_if.slave bus
);

   typedef enum logic [1:0] {TRACK, FALL, LANDED} state_t;

   localparam int FLOOR = SCREEN_H - RECT_H;
   localparam int XMAX  = SCREEN_W - RECT_W;

   localparam logic [POS_W-1:0]   XMAX_PX  = POS_W'(XMAX);
   localparam logic [POS_W-1:0]   FLOOR_PX = POS_W'(FLOOR);
   localparam logic [15:0]        FLOOR_FX = 16'(FLOOR * 16);
   localparam logic signed [17:0] FLOOR_S  = 18'(FLOOR * 16);
   localparam logic signed [17:0] GRAV_S   = 18'(GRAVITY);
   localparam logic signed [17:0] VMAX_S   = 18'(VMAX);
   localparam logic signed [17:0] STOP_S   = 18'(STOP_VEL);

   state_t             state_reg, state_next;
   logic [POS_W-1:0]   x_reg, x_next;
   logic [15:0]        y_fx_reg, y_fx_next;     // Q12.4 vertical position
   logic signed [12:0] vel_reg, vel_next;       // 1/16 px/frame, positive = down
   logic               click_pend_reg, click_pend_next;

   logic               tick;
   logic               click_pulse;
   logic               click_take;
   logic signed [17:0] v1, yn, mag, damp;

   edge_rise u_vblnk_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.vblnk),
      .pulse (tick)
   );

   edge_rise u_click_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.mouse_left),
      .pulse (click_pulse)
   );

   // A click arriving in the tick cycle itself still counts for that tick.
   assign click_take = click_pend_reg | click_pulse;

   // Sequencer state and motion registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= TRACK;
         x_reg          <= '0;
         y_fx_reg       <= '0;
         vel_reg        <= '0;
         click_pend_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         x_reg          <= x_next;
         y_fx_reg       <= y_fx_next;
         vel_reg        <= vel_next;
         click_pend_reg <= click_pend_next;
      end
   end

   // Next-state and per-frame motion update; nothing moves outside a tick.
   always_comb begin
      state_next      = state_reg;
      x_next          = x_reg;
      y_fx_next       = y_fx_reg;
      vel_next        = vel_reg;
      click_pend_next = click_take;

      // Gravity step with terminal-velocity clamp, then candidate position.
      v1 = $signed({{5{vel_reg[12]}}, vel_reg}) + GRAV_S;
      if (v1 > VMAX_S) v1 = VMAX_S;
      yn   = $signed({2'b00, y_fx_reg}) + v1;
      mag  = (v1 < 0) ? -v1 : v1;
      damp = mag - (mag >>> DAMP_SHIFT);

      if (tick) begin
         // A pending click is consumed by every tick, used or not.
         click_pend_next = 1'b0;
         case (state_reg)
            TRACK: begin
               x_next    = clamp_px(bus.mouse_xpos, XMAX_PX);
               y_fx_next = {clamp_px(bus.mouse_ypos, FLOOR_PX), 4'b0000};
               vel_next  = '0;
               if (click_take) state_next = FALL;
            end
            FALL: begin
               if (yn >= FLOOR_S) begin
                  y_fx_next = FLOOR_FX;
                  if (damp < STOP_S) begin
                     vel_next   = '0;
                     state_next = LANDED;
                  end else begin
                     vel_next = 13'(-damp);
                  end
               end else if (yn < 0) begin
                  y_fx_next = '0;
                  vel_next  = '0;
               end else begin
                  y_fx_next = yn[15:0];
                  vel_next  = 13'(v1);
               end
            end
            LANDED: begin
               if (click_take) state_next = TRACK;
            end
            default: state_next = TRACK;
         endcase
      end
   end

   assign bus.rect_x_position = x_reg;
   assign bus.rect_y_position = y_fx_reg[15:4];
   assign bus.falling         = (state_reg == FALL);

endmodule

// File: tb/tb_rect_fall_ctl.sv
// Testbench for rect_fall_ctl: directed scenarios plus randomized frames,
// checked against an integer model of the track/fall/bounce rules.
module tb_rect_fall_ctl;

   localparam int FLOOR = 536;
   localparam int XMAX  = 752;
   localparam int ST_TRACK = 0, ST_FALL = 1, ST_LANDED = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rect_fall_ctl_if bus ();

   rect_fall_ctl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state (plain integers, pixel and 1/16-pixel units).
   int m_st, m_x, m_yf, m_vel;
   bit m_pend, vb_prev, ml_prev;

   function automatic void model_reset();
      m_st = ST_TRACK; m_x = 0; m_yf = 0; m_vel = 0;
      m_pend = 0; vb_prev = 0; ml_prev = 0;
   endfunction

   function automatic void model_tick(input int mx, input int my);
      int v1, yn, a, m;
      case (m_st)
         ST_TRACK: begin
            m_x = (mx > XMAX) ? XMAX : mx;
            m_yf = ((my > FLOOR) ? FLOOR : my) * 16;
            m_vel = 0;
            if (m_pend) m_st = ST_FALL;
         end
         ST_FALL: begin
            v1 = m_vel + 4;
            if (v1 > 512) v1 = 512;
            yn = m_yf + v1;
            if (yn >= FLOOR * 16) begin
               m_yf = FLOOR * 16;
               a = (v1 < 0) ? -v1 : v1;
               m = a - a / 4;
               if (m < 16) begin
                  m_vel = 0;
                  m_st = ST_LANDED;
               end else begin
                  m_vel = -m;
               end
            end else if (yn < 0) begin
               m_yf = 0;
               m_vel = 0;
            end else begin
               m_yf = yn;
               m_vel = v1;
            end
         end
         default: if (m_pend) m_st = ST_TRACK;
      endcase
      m_pend = 0;
   endfunction

   function automatic logic [24:0] model_word();
      return {12'(m_x), 12'(m_yf / 16), (m_st == ST_FALL)};
   endfunction

   function automatic logic [24:0] dut_word();
      return {bus.rect_x_position, bus.rect_y_position, bus.falling};
   endfunction

   // Apply one cycle of inputs, advance the model to the coming edge, then
   // step past that edge so outputs can be sampled.
   task automatic cyc(input bit vb, input int mx, input int my, input bit ml);
      bus.vblnk      = vb;
      bus.mouse_xpos = 12'(mx);
      bus.mouse_ypos = 12'(my);
      bus.mouse_left = ml;
      if (ml && !ml_prev) m_pend = 1;
      if (vb && !vb_prev) model_tick(mx, my);
      vb_prev = vb;
      ml_prev = ml;
      @(posedge clk);
      #1;
   endtask

   // One 8-cycle frame: vblank high on cycles 6..7, optional click on click_at.
   task automatic frame(input int mx, input int my, input int click_at);
      for (int c = 0; c < 8; c++) cyc(c >= 6, mx, my, c == click_at);
      $display("tick: x=%0d y=%0d falling=%0b", bus.rect_x_position,
               bus.rect_y_position, bus.falling);
   endtask

   task automatic test_reset();
      logic [24:0] g;
      bus.vblnk = 0; bus.mouse_xpos = 12'd321; bus.mouse_ypos = 12'd123; bus.mouse_left = 0;
      rst_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      g = dut_word();
      checks++;
      if (g !== 25'd0)
         $display("FAIL reset_hold: got (%0d,%0d,%0b) expected (0,0,0)", g[24:13], g[12:1], g[0]);
      rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         cyc(0, $urandom_range(0, 1023), $urandom_range(0, 1023), 0);
         g = dut_word();
         checks++;
         if (g !== 25'd0) begin
            errors++;
            $display("FAIL reset_no_tick: got (%0d,%0d,%0b) expected (0,0,0)", g[24:13], g[12:1], g[0]);
         end
      end
      if (g !== 25'd0 && checks == 1) errors++;
   endtask

   task automatic test_track();
      logic [24:0] g, e;
      for (int i = 0; i < 6; i++) begin
         cyc(0, 900, 700, 0);
         g = dut_word(); e = 25'd0;
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL track_pre_tick: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
         end
      end
      cyc(1, 900, 700, 0);
      g = dut_word(); e = {12'd752, 12'd536, 1'b0};
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL track_saturate: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
      end
      $display("tick: x=%0d y=%0d falling=%0b", g[24:13], g[12:1], g[0]);
      cyc(1, 900, 700, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 100, 50, 0);
         g = dut_word();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL track_midframe_hold: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
         end
      end
      cyc(1, 100, 50, 0);
      g = dut_word(); e = {12'd100, 12'd50, 1'b0};
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL track_follow: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
      end
      $display("tick: x=%0d y=%0d falling=%0b", g[24:13], g[12:1], g[0]);
      cyc(1, 100, 50, 0);
   endtask

   task automatic test_fall_start();
      logic [24:0] g, e;
      int ypx [4] = '{0, 0, 1, 2};
      for (int c = 0; c < 6; c++) begin
         cyc(0, 100, 0, c == 2);
         g = dut_word(); e = {12'd100, 12'd50, 1'b0};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL click_pre_tick: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
         end
      end
      cyc(1, 100, 0, 0);
      cyc(1, 100, 0, 0);
      g = dut_word(); e = {12'd100, 12'd0, 1'b1};
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL fall_enter: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
      end
      for (int k = 0; k < 4; k++) begin
         frame($urandom_range(0, 1023), $urandom_range(0, 1023), -1);
         g = dut_word(); e = {12'd100, 12'(ypx[k]), 1'b1};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL fall_gravity_k%0d: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", k + 1, g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
         end
      end
   endtask

   task automatic test_bounce_land();
      logic [24:0] g, e;
      bit saw_floor = 0, saw_rise = 0;
      int n = 0;
      while (m_st != ST_LANDED && n < 2000) begin
         // Clicks during the fall are consumed and must not alter the path.
         frame($urandom_range(0, 1023), $urandom_range(0, 1023),
               ($urandom_range(0, 3) == 0) ? 2 : -1);
         n++;
         g = dut_word(); e = model_word();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL bounce_frame%0d: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", n, g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
         end
         if (g[12:1] == 12'd536) saw_floor = 1;
         else if (saw_floor && g[12:1] < 12'd536) saw_rise = 1;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL bounce_timeout: got %0d frames without landing, required fewer than 2000", n);
      end
      checks++;
      if (saw_floor !== 1'b1) begin
         errors++;
         $display("FAIL bounce_floor_hit: got %0b required 1", saw_floor);
      end
      checks++;
      if (saw_rise !== 1'b1) begin
         errors++;
         $display("FAIL bounce_rebound: got %0b required 1", saw_rise);
      end
      for (int i = 0; i < 10; i++) begin
         frame($urandom_range(0, 1023), $urandom_range(0, 1023), -1);
         g = dut_word(); e = {12'd100, 12'd536, 1'b0};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL landed_hold%0d: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", i, g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
         end
      end
   endtask

   task automatic test_landed_click();
      logic [24:0] g, e;
      frame(300, 200, 3);
      g = dut_word(); e = {12'd100, 12'd536, 1'b0};
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL landed_click_hold: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
      end
      frame(300, 200, -1);
      g = dut_word(); e = {12'd300, 12'd200, 1'b0};
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL landed_resume_track: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
      end
   endtask

   task automatic test_async_reset();
      logic [24:0] g, e;
      frame(200, 0, 7);          // click lands just after vblank rises
      frame(200, 0, -1);         // this tick enters FALL
      frame(200, 0, -1);
      frame(200, 0, -1);
      g = dut_word();
      checks++;
      if (g[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_fall: got falling=%0b required 1", g[0]);
      end
      cyc(0, 200, 0, 0);
      #2 rst_n = 0;
      #1;
      g = dut_word();
      checks++;
      if (g !== 25'd0) begin
         errors++;
         $display("FAIL rst_async_clear: got (%0d,%0d,%0b) expected (0,0,0)", g[24:13], g[12:1], g[0]);
      end
      model_reset();
      #1 rst_n = 1;
      @(posedge clk);
      #1;
      frame(333, 444, -1);
      g = dut_word(); e = {12'd333, 12'd444, 1'b0};
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL rst_then_track: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
      end
   endtask

   task automatic test_random();
      logic [24:0] g, e;
      int mx, my, click_at;
      for (int f = 0; f < 300; f++) begin
         mx = $urandom_range(0, 1023);
         my = $urandom_range(0, 1023);
         click_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
         for (int c = 0; c < 8; c++) begin
            // Mouse wanders mid-frame; only the value at the tick matters.
            if (c == 3) begin
               mx = $urandom_range(0, 1023);
               my = $urandom_range(0, 1023);
            end
            cyc(c >= 6, mx, my, c == click_at);
            g = dut_word(); e = model_word();
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL random_f%0d_c%0d: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)", f, c, g[24:13], g[12:1], g[0], e[24:13], e[12:1], e[0]);
            end
         end
         $display("frame %0d: mouse=(%0d,%0d) click@%0d -> x=%0d y=%0d falling=%0b",
                  f, mx, my, click_at, g[24:13], g[12:1], g[0]);
      end
   endtask

   initial begin
      test_reset();
      test_track();
      test_fall_start();
      test_bounce_land();
      test_landed_click();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
